// File: rtl/spi_shift_pkg.sv
// Shared constants and helpers for the SPI master serial data engine.
package spi_shift_pkg;

  localparam int MAX_CHAR        = 32;
  localparam int CHAR_LEN_BITS   = 5;
  localparam int SPI_DIVIDER_LEN = 8;
  localparam int CNT_W           = CHAR_LEN_BITS + 1;

  typedef enum logic {IDLE, XFER} state_t;

  // Maps the k-th bit on the wire to its register position. A length of
  // MAX_CHAR wraps to 0 in CHAR_LEN_BITS, so len-1-k still lands correctly.
  function automatic logic [CHAR_LEN_BITS-1:0] bit_pos(
    input logic [CHAR_LEN_BITS-1:0] k,
    input logic [CHAR_LEN_BITS-1:0] len,
    input logic                     lsb_first
  );
    return lsb_first ? k : (len - k - CHAR_LEN_BITS'(1));
  endfunction

endpackage

// File: rtl/spi_shift.sv
// SPI master shift engine: drives mosi, samples miso and tracks sclk edges
// from the clock generator's strobes.
module spi_shift
  import spi_shift_pkg::*;
(
  input  logic                     wb_clk,
  input  logic                     wb_reset,
  input  logic                     go,
  input  logic [CHAR_LEN_BITS-1:0] char_len,
  input  logic                     lsb,
  input  logic                     tx_neg,
  input  logic                     rx_neg,
  input  logic                     cpol_0,
  input  logic                     cpol_1,
  input  logic                     wr_en,
  input  logic [MAX_CHAR-1:0]      wr_data,
  input  logic                     miso,
  output logic                     tip,
  output logic                     lstclk,
  output logic                     mosi,
  output logic [MAX_CHAR-1:0]      rx_data,
  output logic                     done
);

  state_t              state;
  logic [CNT_W-1:0]    pcnt;
  logic [CNT_W-1:0]    tcnt;
  logic [CNT_W-1:0]    rcnt;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    len_new;
  logic [MAX_CHAR-1:0] tx_reg;
  logic [MAX_CHAR-1:0] tx_next;
  logic                tx_strobe;
  logic                rx_strobe;

  // tx_next lets a same-cycle write feed the preloaded first bit.
  always_comb begin
    len_new   = (char_len == '0) ? CNT_W'(MAX_CHAR) : {1'b0, char_len};
    tx_next   = wr_en ? wr_data : tx_reg;
    tx_strobe = tx_neg ? cpol_1 : cpol_0;
    rx_strobe = rx_neg ? cpol_1 : cpol_0;
  end

  assign lstclk = tip && (pcnt == len_q);

  always_ff @(posedge wb_clk) begin
    if (wb_reset) begin
      state   <= IDLE;
      tip     <= 1'b0;
      mosi    <= 1'b0;
      done    <= 1'b0;
      rx_data <= '0;
      tx_reg  <= '0;
      pcnt    <= '0;
      tcnt    <= '0;
      rcnt    <= '0;
      len_q   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) begin
            tx_reg <= wr_data;
          end
          if (go) begin
            state   <= XFER;
            tip     <= 1'b1;
            pcnt    <= '0;
            rcnt    <= '0;
            rx_data <= '0;
            len_q   <= len_new;
            if (tx_neg) begin
              mosi <= tx_next[bit_pos('0, len_new[CHAR_LEN_BITS-1:0], lsb)];
              tcnt <= CNT_W'(1);
            end else begin
              tcnt <= '0;
            end
          end
        end
        XFER: begin
          if (cpol_0 && (pcnt < len_q)) begin
            pcnt <= pcnt + CNT_W'(1);
          end
          if (tx_strobe && (tcnt < len_q)) begin
            mosi <= tx_reg[bit_pos(tcnt[CHAR_LEN_BITS-1:0], len_q[CHAR_LEN_BITS-1:0], lsb)];
            tcnt <= tcnt + CNT_W'(1);
          end
          if (rx_strobe && (rcnt < len_q)) begin
            rx_data[bit_pos(rcnt[CHAR_LEN_BITS-1:0], len_q[CHAR_LEN_BITS-1:0], lsb)] <= miso;
            rcnt <= rcnt + CNT_W'(1);
          end
          // Final falling edge: a sample due on this strobe was taken above.
          if (cpol_1 && (pcnt == len_q)) begin
            tip   <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
